uart_word_buffer: RTL
=====================

Name: uart_word_buffer

Overview:
Parametrised byte-to-word packer and unpacker between the UART receiver/transmitter pair and the encoder/decoder datapath.
- Collects NUM_BYTES received bytes, LSB byte first, into a word and flags it complete.
- On command, streams the held word back out through the UART transmitter one byte at a time with a busy handshake.
- Adds behaviour the previous hard-wired 4-byte buffer lacked: partial-frame timeout, overflow detection and paced transmission.

Parameters:
NUM_BYTES, 4, bytes per word (1..16).
TIMEOUT_CYCLES, 1000000, idle clk cycles after which a partial frame is discarded; 0 disables the timeout.
CNT_W, $clog2(NUM_BYTES+1), width of byte counters.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
rx_valid  in  1  one-cycle strobe, rx_data valid (from async_receiver RxD_data_ready).
rx_data  in  8  received byte.
clear  in  1  one-cycle debounced command; empties buffer.
send_start  in  1  one-cycle debounced command; transmit held bytes.
tx_busy  in  1  transmitter busy.
tx_start  out  1  one-cycle start strobe to transmitter.
tx_data  out  8  byte to transmit; stable while tx_busy=1.
word_out  out  8*NUM_BYTES  assembled word; byte k at bits [8k+7:8k].
word_valid  out  1  high while buffer is full.
byte_count  out  CNT_W  bytes currently held.
sending  out  1  high while the transmit FSM is not in T_IDLE.
overflow  out  1  sticky; a byte arrived while full or sending.
timeout_err  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) is the highest priority. It zeroes word_out, byte_count, the idle counter, tx_data and every flag; tx_start=0; the FSM goes to T_IDLE. Reset mid-transmission abandons the stream; the transmitter's in-flight byte is not tracked.
- Receive path, active when sending=0:
  - rx_valid with byte_count<NUM_BYTES writes rx_data to slot byte_count and increments byte_count on the same edge. The first byte goes to slot 0. Visible 1 cycle later.
  - word_valid = (byte_count==NUM_BYTES), combinational from the count register.
  - rx_valid with word_valid=1, or with sending=1: byte dropped, overflow<=1. overflow is cleared only by rst or clear.
- Clear: clear=1 with sending=0 sets byte_count<=0 and overflow<=0. Clear beats a simultaneous rx_valid, which is dropped without setting overflow. word_out contents are retained but are stale. Clear while sending=1 is ignored.
- Timeout:
  - The idle counter resets on every rx_valid and whenever byte_count is 0 or NUM_BYTES.
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT_CYCLES: byte_count<=0, timeout_err pulses for 1 cycle, and the counter resets.
  - A full word never times out.
- Transmit FSM, states T_IDLE, T_LOAD, T_WAITHI, T_WAITLO:
  - T_IDLE: send_start=1 and byte_count>0 latches n=byte_count, sets idx<=0, goes to T_LOAD. send_start with byte_count=0, or while not in T_IDLE, is ignored.
  - T_LOAD: if tx_busy=0, drive tx_data<=word_out[8*idx+:8], pulse tx_start for exactly 1 cycle, go to T_WAITHI. If tx_busy=1, wait here.
  - T_WAITHI: wait for tx_busy=1, then go to T_WAITLO. If tx_busy does not rise within 4 cycles, treat the byte as sent and go to T_WAITLO.
  - T_WAITLO: wait for tx_busy=0, then idx++. If idx==n-1 at that point, go to T_IDLE, set byte_count<=0 and reset the idle counter; else go to T_LOAD.
- Transmit ordering and timing:
  - Bytes go out in order slot 0..n-1; a partial buffer sends only the bytes it holds.
  - tx_data holds its value until the next T_LOAD.
  - Latency from send_start to tx_start is 2 cycles, with tx_busy=0.
- sending=1 in every state except T_IDLE. byte_count changes only via rst, rx, clear, timeout or send completion.

Test Plan:
- Fill word: rst, then rx_valid with 0x11,0x22,0x33,0x44 → byte_count=4, word_valid=1, word_out=0x44332211, overflow=0.
- Overflow and clear: with the buffer full, rx_valid 0x55 → word_out unchanged, overflow=1. Then clear → byte_count=0, overflow=0, word_valid=0.
- Send full word: load 0x44332211, send_start, tx model holding busy 10 cycles per byte → tx_start pulses 4 times with tx_data 0x11,0x22,0x33,0x44. No tx_start while tx_busy=1. Afterwards byte_count=0, sending=0.
- Partial send and ignores: rx 0xA5,0x5A, then send_start → 2 bytes sent, 0xA5 then 0x5A. rx_valid during sending → dropped, overflow=1. send_start with byte_count=0 → no tx_start.
- Timeout: TIMEOUT_CYCLES=20, rx 0x01 then idle → timeout_err pulses exactly 1 cycle after 20 idle cycles, byte_count=0. Then rx 4 bytes → word_out=new bytes, and no timeout while full.
- Reset mid-operation: assert rst during T_WAITLO of byte 2 → next cycle sending=0, byte_count=0, tx_start=0, overflow=0. Repeat with NUM_BYTES=1: rx 0x7E → word_valid=1, send emits 0x7E.

Source files
------------

// File: rtl/uart_word_buffer.sv
// uart_word_buffer: packs UART bytes (LSB byte first) into a NUM_BYTES word and streams
// the held bytes back out through the UART transmitter with a busy handshake.
// Also provides a partial-frame timeout, sticky overflow detection and paced transmission.
module uart_word_buffer #(
    parameter int unsigned NUM_BYTES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = $clog2(NUM_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   clear,
    input  logic                   send_start,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [8*NUM_BYTES-1:0] word_out,
    output logic                   word_valid,
    output logic [CNT_W-1:0]       byte_count,
    output logic                   sending,
    output logic                   overflow,
    output logic                   timeout_err
);

    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  FullCount = CNT_W'(NUM_BYTES);
    localparam logic [IDLE_W-1:0] IdleLast  =
        IDLE_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {TIdle, TLoad, TWaitHi, TWaitLo} tx_state_e;

    tx_state_e              state_q, state_d;
    logic [8*NUM_BYTES-1:0] word_q, word_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic [1:0]             wait_q, wait_d;
    logic                   tx_start_q, tx_start_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   overflow_q, overflow_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_fsm;
    logic                   full;

    assign busy_fsm = (state_q != TIdle);
    assign full     = (count_q == FullCount);

    // Next-state logic: receive/clear path, idle timeout and transmit FSM.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        count_d    = count_q;
        n_d        = n_q;
        idx_d      = idx_q;
        idle_d     = '0;
        wait_d     = wait_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        overflow_d = overflow_q;
        timeout_d  = 1'b0;

        // Receive path; while transmitting every incoming byte is dropped as overflow.
        if (!busy_fsm) begin
            if (clear) begin
                count_d    = '0;
                overflow_d = 1'b0;
            end else if (rx_valid) begin
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                        if (count_q == CNT_W'(k)) begin
                            word_d[8*k +: 8] = rx_data;
                        end
                    end
                    count_d = count_q + 1'b1;
                end
            end
        end else if (rx_valid) begin
            overflow_d = 1'b1;
        end

        // Partial-frame timeout. Held at zero while transmitting so a frame being
        // sent is never reported as discarded.
        if ((TIMEOUT_CYCLES != 0) && !busy_fsm && !rx_valid && !clear &&
            (count_q != '0) && !full) begin
            if (idle_q == IdleLast) begin
                count_d   = '0;
                timeout_d = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        unique case (state_q)
            TIdle: begin
                if (send_start && (count_q != '0)) begin
                    n_d     = count_q;
                    idx_d   = '0;
                    state_d = TLoad;
                end
            end
            TLoad: begin
                if (!tx_busy) begin
                    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                        if (idx_q == CNT_W'(k)) begin
                            tx_data_d = word_q[8*k +: 8];
                        end
                    end
                    tx_start_d = 1'b1;
                    wait_d     = 2'd0;
                    state_d    = TWaitHi;
                end
            end
            TWaitHi: begin
                // A transmitter that never raises busy must not stall the stream.
                if (tx_busy || (wait_q == 2'd3)) begin
                    state_d = TWaitLo;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            TWaitLo: begin
                if (!tx_busy) begin
                    if (idx_q == n_q - 1'b1) begin
                        state_d = TIdle;
                        count_d = '0;
                        idle_d  = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = TLoad;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TIdle;
            word_q     <= '0;
            count_q    <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            idle_q     <= '0;
            wait_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            count_q    <= count_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            idle_q     <= idle_d;
            wait_q     <= wait_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign word_out    = word_q;
    assign word_valid  = full;
    assign byte_count  = count_q;
    assign sending     = busy_fsm;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;

endmodule
